// File: rtl/prop_monitor_if.sv
`default_nettype none
// ============================================================================
//  Module   : prop_monitor_if
//  Brief    : Sample and failure-report bundle between an observed FSM and
//             its property monitor.
//  Revision : 1.0 - initial release
// ============================================================================
interface prop_monitor_if #(
    parameter int SW = 3,
    parameter int DW = 8
);
    logic          en;
    logic          bad;
    logic [SW-1:0] state_in;
    logic          rpt_ready;
    logic          rpt_valid;
    logic [1:0]    rpt_kind;
    logic [DW-1:0] rpt_depth;
    logic [SW-1:0] rpt_state;
    logic          fail_sticky;
    logic [DW-1:0] depth;

    modport master (
        output en,
        output bad,
        output state_in,
        output rpt_ready,
        input  rpt_valid,
        input  rpt_kind,
        input  rpt_depth,
        input  rpt_state,
        input  fail_sticky,
        input  depth
    );

    modport slave (
        input  en,
        input  bad,
        input  state_in,
        input  rpt_ready,
        output rpt_valid,
        output rpt_kind,
        output rpt_depth,
        output rpt_state,
        output fail_sticky,
        output depth
    );
endinterface
`default_nettype wire

// File: rtl/prop_monitor.sv
`default_nettype none
// ============================================================================
//  Module   : prop_monitor
//  Brief    : Safety and bounded-liveness checker; reports the first
//             violation over a valid/ready port and then stays failed.
//  Revision : 1.0 - initial release
// ============================================================================
module prop_monitor #(
    parameter int SW    = 3,
    parameter int HOME  = 0,
    parameter int BOUND = 3,
    parameter int DW    = 8
) (
    input  logic          clk,
    input  logic          reset,
    prop_monitor_if.slave mon
);

    localparam int              RW          = $clog2(BOUND + 1);
    localparam logic [RW:0]     c_bound     = (RW + 1)'(BOUND);
    localparam logic [SW-1:0]   c_home      = SW'(HOME);
    localparam logic [DW-1:0]   c_depth_max = '1;

    typedef enum logic [1:0] {
        S_MON  = 2'd0,
        S_HOLD = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [RW-1:0] run_q, run_d;
    logic [DW-1:0] depth_q, depth_d;
    logic          rpt_valid_q, rpt_valid_d;
    logic [1:0]    rpt_kind_q, rpt_kind_d;
    logic [DW-1:0] rpt_depth_q, rpt_depth_d;
    logic [SW-1:0] rpt_state_q, rpt_state_d;
    logic          fail_sticky_q, fail_sticky_d;

    logic          w_is_home;
    logic [RW:0]   w_run_inc;
    logic          w_safe_fail;
    logic          w_live_fail;
    logic [DW-1:0] w_depth_inc;

    assign w_is_home   = (mon.state_in == c_home);
    assign w_run_inc   = {1'b0, run_q} + (RW + 1)'(1);
    assign w_safe_fail = mon.bad;
    assign w_live_fail = !w_is_home && (w_run_inc == c_bound);
    assign w_depth_inc = (depth_q == c_depth_max) ? depth_q : depth_q + DW'(1);

    always_comb begin
        state_d       = state_q;
        run_d         = run_q;
        depth_d       = depth_q;
        rpt_valid_d   = rpt_valid_q;
        rpt_kind_d    = rpt_kind_q;
        rpt_depth_d   = rpt_depth_q;
        rpt_state_d   = rpt_state_q;
        fail_sticky_d = fail_sticky_q;

        case (state_q)
            S_MON: begin
                if (mon.en) begin
                    depth_d = w_depth_inc;
                    if (w_safe_fail || w_live_fail) begin
                        // The record carries the index of this sample, not the bumped count.
                        rpt_kind_d    = {w_live_fail, w_safe_fail};
                        rpt_depth_d   = depth_q;
                        rpt_state_d   = mon.state_in;
                        rpt_valid_d   = 1'b1;
                        fail_sticky_d = 1'b1;
                        state_d       = S_HOLD;
                    end else begin
                        // Truncation is safe: reaching BOUND always takes the failure path.
                        run_d = w_is_home ? '0 : w_run_inc[RW-1:0];
                    end
                end
            end
            S_HOLD: begin
                if (rpt_valid_q && mon.rpt_ready) begin
                    rpt_valid_d = 1'b0;
                    state_d     = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_DONE;
            end
            default: begin
                state_d = S_MON;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= S_MON;
            run_q         <= '0;
            depth_q       <= '0;
            rpt_valid_q   <= 1'b0;
            rpt_kind_q    <= '0;
            rpt_depth_q   <= '0;
            rpt_state_q   <= '0;
            fail_sticky_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            run_q         <= run_d;
            depth_q       <= depth_d;
            rpt_valid_q   <= rpt_valid_d;
            rpt_kind_q    <= rpt_kind_d;
            rpt_depth_q   <= rpt_depth_d;
            rpt_state_q   <= rpt_state_d;
            fail_sticky_q <= fail_sticky_d;
        end
    end

    assign mon.rpt_valid   = rpt_valid_q;
    assign mon.rpt_kind    = rpt_kind_q;
    assign mon.rpt_depth   = rpt_depth_q;
    assign mon.rpt_state   = rpt_state_q;
    assign mon.fail_sticky = fail_sticky_q;
    assign mon.depth       = depth_q;

endmodule
`default_nettype wire

// File: tb/tb_prop_monitor.sv
`default_nettype none
// ============================================================================
//  Module   : tb_prop_monitor
//  Brief    : Randomized and directed bench for prop_monitor against a
//             sample-index reference model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_prop_monitor;

    localparam int SW    = 3;
    localparam int HOME  = 0;
    localparam int BOUND = 3;
    localparam int DW    = 8;
    localparam int DMAX  = (1 << DW) - 1;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    prop_monitor_if #(.SW(SW), .DW(DW)) bus ();

    prop_monitor #(.SW(SW), .HOME(HOME), .BOUND(BOUND), .DW(DW)) dut (
        .clk   (clk),
        .reset (reset),
        .mon   (bus)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, req, $time);
        end
    endtask

    // Reference model: failure decided from sample indices, phase 0/1/2 = watching/reporting/finished.
    bit m_live = 1'b0;
    int m_n, m_last_home, m_phase, m_kind, m_rdepth, m_rstate;
    bit m_sf, m_lf;

    always @(posedge clk) begin
        if (reset) begin
            m_live = 1'b1; m_n = 0; m_last_home = -1; m_phase = 0;
            m_kind = 0; m_rdepth = 0; m_rstate = 0;
        end else if (m_live) begin
            if (m_phase == 0 && bus.en) begin
                m_sf = bus.bad;
                m_lf = (int'(bus.state_in) != HOME) && (m_n - m_last_home >= BOUND);
                if (m_sf || m_lf) begin
                    m_kind   = (m_lf ? 2 : 0) + (m_sf ? 1 : 0);
                    m_rdepth = (m_n > DMAX) ? DMAX : m_n;
                    m_rstate = int'(bus.state_in);
                    m_phase  = 1;
                end else if (int'(bus.state_in) == HOME) begin
                    m_last_home = m_n;
                end
                m_n++;
            end else if (m_phase == 1 && bus.rpt_ready) begin
                m_phase = 2;
            end
        end
    end

    always @(negedge clk) begin
        if (m_live) begin
            chk("rpt_valid",   32'(bus.rpt_valid),   32'(m_phase == 1));
            chk("fail_sticky", 32'(bus.fail_sticky), 32'(m_phase != 0));
            chk("depth",       32'(bus.depth),       32'((m_n > DMAX) ? DMAX : m_n));
            chk("rpt_kind",    32'(bus.rpt_kind),    32'(m_kind));
            chk("rpt_depth",   32'(bus.rpt_depth),   32'(m_rdepth));
            chk("rpt_state",   32'(bus.rpt_state),   32'(m_rstate));
        end
    end

    task automatic step(input bit e, input bit b, input int s, input bit r);
        bus.en = e; bus.bad = b; bus.state_in = SW'(s); bus.rpt_ready = r;
        @(negedge clk);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step(0, 0, 0, 0);
        reset = 1'b0;
    endtask

    task automatic lit_rec(input string tag, input int v, input int k, input int d, input int s);
        chk({tag, "_valid"}, 32'(bus.rpt_valid), 32'(v));
        chk({tag, "_kind"},  32'(bus.rpt_kind),  32'(k));
        chk({tag, "_depth"}, 32'(bus.rpt_depth), 32'(d));
        chk({tag, "_state"}, 32'(bus.rpt_state), 32'(s));
    endtask

    int seq [3] = '{0, 2, 6};

    initial begin
        bus.en = 0; bus.bad = 0; bus.state_in = '0; bus.rpt_ready = 0;
        @(negedge clk);
        do_reset();
        chk("reset_sticky", 32'(bus.fail_sticky), 0);
        chk("reset_depth",  32'(bus.depth),       0);

        for (int i = 0; i < 20; i++) step(1, 0, seq[i % 3], 0);
        chk("clean_valid",  32'(bus.rpt_valid),   0);
        chk("clean_sticky", 32'(bus.fail_sticky), 0);
        chk("clean_depth",  32'(bus.depth),       20);

        do_reset();
        for (int i = 0; i < 6; i++) step(1, i == 5, seq[i % 3], 1);
        lit_rec("safety", 1, 1, 5, 6);
        step(0, 0, 0, 1);
        chk("safety_ack_valid",  32'(bus.rpt_valid),   0);
        chk("safety_ack_sticky", 32'(bus.fail_sticky), 1);
        chk("safety_ack_depth",  32'(bus.depth),       6);
        step(1, 1, 2, 1);
        chk("done_valid", 32'(bus.rpt_valid), 0);
        chk("done_depth", 32'(bus.depth),     6);

        do_reset();
        step(1, 0, 0, 0); step(1, 0, 2, 0); step(1, 0, 2, 0); step(1, 0, 2, 0);
        lit_rec("live", 1, 2, 3, 2);
        for (int i = 0; i < 4; i++) begin
            step($urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 7), 0);
            lit_rec("hold", 1, 2, 3, 2);
        end
        step(0, 0, 0, 1);

        do_reset();
        step(1, 0, 0, 0); step(1, 0, 2, 0); step(1, 0, 5, 0); step(1, 1, 7, 0);
        lit_rec("both", 1, 3, 3, 7);

        do_reset();
        step(1, 0, 0, 0); step(0, 0, 2, 0); step(0, 0, 2, 0); step(1, 0, 6, 0); step(1, 0, 0, 0);
        chk("en_gap_depth", 32'(bus.depth),     3);
        chk("en_gap_valid", 32'(bus.rpt_valid), 0);

        do_reset();
        step(1, 0, 0, 0); step(1, 0, 2, 0); step(1, 0, 2, 0); step(1, 0, 2, 0);
        chk("abort_pre_valid", 32'(bus.rpt_valid), 1);
        do_reset();
        chk("abort_valid",  32'(bus.rpt_valid),   0);
        chk("abort_sticky", 32'(bus.fail_sticky), 0);
        chk("abort_depth",  32'(bus.depth),       0);
        step(1, 0, 2, 0); step(1, 0, 2, 0); step(1, 0, 2, 0);
        lit_rec("resume", 1, 2, 2, 2);

        do_reset();
        for (int i = 0; i < 300; i++) step(1, 0, (i % 2 == 0) ? 0 : $urandom_range(1, 7), 0);
        chk("sat_depth", 32'(bus.depth), DMAX);
        step(1, 1, 3, 0);
        lit_rec("sat", 1, 1, DMAX, 3);

        for (int ep = 0; ep < 10; ep++) begin
            do_reset();
            for (int i = 0; i < 60; i++) begin
                step($urandom_range(0, 3) != 0,
                     $urandom_range(0, 29) == 0,
                     ($urandom_range(0, 2) == 0) ? HOME : $urandom_range(0, 7),
                     $urandom_range(0, 1));
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
